smc_stream: RTL and testbench

SMC_STREAM -- requirements
Module: smc_stream

---
 rtl/smc_stream_if.sv | 28 ++
 rtl/smc_stream.sv | 142 ++++++++++++++
 tb/tb_smc_stream.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/smc_stream_if.sv
// smc_stream_if -- handshake bundle for smc_stream.
//   Input side : in_valid/in_ready handshake carrying in_mode, in_w, in_vgs, in_vds.
//   Output side: out_valid/out_ready handshake carrying out_data (3*IW bits).
//   master : the producer/consumer environment around the block.
//   slave  : the smc_stream block itself.
interface smc_stream_if #(
    parameter int IW = 3
) ();
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_mode;
    logic [IW-1:0]   in_w;
    logic [IW-1:0]   in_vgs;
    logic [IW-1:0]   in_vds;
    logic            out_valid;
    logic            out_ready;
    logic [3*IW-1:0] out_data;

    modport master (
        output in_valid, in_mode, in_w, in_vgs, in_vds, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_mode, in_w, in_vgs, in_vds, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/smc_stream.sv
// smc_stream -- per-packet transistor metric ranking.
//   Each accepted beat describes one transistor (W, V_GS, V_DS). Its value
//   V = W * metric (gm or Id, square-law model with Vt = 1) is inserted into
//   an ascending sorted array. After N beats the three smallest or largest
//   entries are divided by 3 and combined into a plain or weighted mean.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active high
//   s    : smc_stream_if.slave (in_* beat handshake, out_* result handshake)
module smc_stream #(
    parameter int N  = 6,
    parameter int IW = 3
) (
    input  logic         clk,
    input  logic         rst,
    smc_stream_if.slave  s
);
    localparam int DW = 3 * IW;       // value / result width
    localparam int MW = 2 * IW + 1;   // metric intermediate width (holds 2*Vov*Vds)
    localparam int SW = DW + 4;       // weighted-sum width (12 * max p)
    localparam int CW = $clog2(N);

    localparam logic [IW-1:0] ONE_I  = 1;
    localparam logic [CW-1:0] LAST   = CW'(N - 1);
    localparam logic [CW-1:0] ONE_C  = 1;
    localparam logic [DW-1:0] THREE  = 3;
    localparam logic [SW-1:0] K3     = 3;
    localparam logic [SW-1:0] K4     = 4;
    localparam logic [SW-1:0] K5     = 5;
    localparam logic [SW-1:0] K12    = 12;

    typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;

    state_t                r_state, w_next;
    logic [CW-1:0]         r_cnt;
    logic [1:0]            r_mode;
    logic [N-1:0][DW-1:0]  r_sort;
    logic [DW-1:0]         r_out;

    logic                  w_acc;
    logic [IW-1:0]         w_vov;
    logic                  w_tri;
    logic [MW-1:0]         w_vdsx, w_vovx, w_metric;
    logic [DW-1:0]         w_val;
    logic [N-1:0]          w_gt;
    logic [N-1:0][DW-1:0]  w_ins;
    logic [DW-1:0]         w_e0, w_e1, w_e2;
    logic [DW-1:0]         w_p0, w_p1, w_p2;
    logic [SW-1:0]         w_sum, w_wsum, w_res_wide;
    logic [DW-1:0]         w_res;

    assign s.in_ready  = (r_state == IDLE) || (r_state == LOAD);
    assign s.out_valid = (r_state == OUT);
    assign s.out_data  = r_out;
    assign w_acc       = s.in_valid && s.in_ready;

    // ---------------- per-beat value ----------------
    always_comb begin
        w_vov    = (s.in_vgs != '0) ? (s.in_vgs - ONE_I) : '0;
        w_tri    = (s.in_vds <= w_vov);
        w_vdsx   = MW'(s.in_vds);
        w_vovx   = MW'(w_vov);
        w_metric = '0;
        if (!s.in_mode[0] && !(r_state == LOAD)) begin
            w_metric = w_tri ? (w_vdsx << 1) : (w_vovx << 1);
        end else if (!r_mode[0] && (r_state == LOAD)) begin
            w_metric = w_tri ? (w_vdsx << 1) : (w_vovx << 1);
        end else begin
            // Triode Id is never negative because Vds <= Vov there.
            w_metric = w_tri ? (((w_vovx * w_vdsx) << 1) - (w_vdsx * w_vdsx))
                             : (w_vovx * w_vovx);
        end
        w_val = DW'(s.in_w) * DW'(w_metric);
    end

    // ---------------- sorted insertion ----------------
    // Slots at or beyond the current beat count are treated as +infinity,
    // so stale contents from the previous packet never need clearing.
    always_comb begin
        w_gt  = '0;
        w_ins = '0;
        for (int i = 0; i < N; i++) begin
            w_gt[i] = (CW'(i) >= r_cnt) || (r_sort[i] > w_val);
        end
        w_ins[0] = w_gt[0] ? w_val : r_sort[0];
        for (int i = 1; i < N; i++) begin
            if (!w_gt[i])          w_ins[i] = r_sort[i];
            else if (!w_gt[i-1])   w_ins[i] = w_val;
            else                   w_ins[i] = r_sort[i-1];
        end
    end

    // ---------------- result ----------------
    // e0 <= e1 <= e2 in sorted order, so p0 comes from e2.
    always_comb begin
        w_e0       = r_mode[1] ? r_sort[N-3] : r_sort[0];
        w_e1       = r_mode[1] ? r_sort[N-2] : r_sort[1];
        w_e2       = r_mode[1] ? r_sort[N-1] : r_sort[2];
        w_p0       = w_e2 / THREE;
        w_p1       = w_e1 / THREE;
        w_p2       = w_e0 / THREE;
        w_sum      = SW'(w_p0) + SW'(w_p1) + SW'(w_p2);
        w_wsum     = K3 * SW'(w_p0) + K4 * SW'(w_p1) + K5 * SW'(w_p2);
        w_res_wide = r_mode[0] ? (w_wsum / K12) : (w_sum / K3);
        w_res      = DW'(w_res_wide);
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_acc) w_next = LOAD;
            LOAD:    if (w_acc && (r_cnt == LAST)) w_next = CALC;
            CALC:    w_next = OUT;
            OUT:     if (s.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_mode <= '0;
            r_sort <= '0;
            r_out  <= '0;
        end else begin
            if (w_acc) begin
                r_sort <= w_ins;
                if (r_state == IDLE) r_mode <= s.in_mode;
                r_cnt  <= (r_cnt == LAST) ? '0 : (r_cnt + ONE_C);
            end
            if (r_state == CALC) r_out <= w_res;
            else if ((r_state == OUT) && s.out_ready) r_out <= '0;
        end
    end
endmodule

// File: tb/tb_smc_stream.sv
module tb_smc_stream;
    typedef int arr6_t[6];
    typedef struct {
        logic [1:0] mode;
        arr6_t      w;
        arr6_t      vg;
        arr6_t      vd;
        int         exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    smc_stream_if #(.IW(3)) bus ();
    smc_stream #(.N(6), .IW(3)) dut (.clk(clk), .rst(rst), .s(bus));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: square-law metric per transistor, sort, pick three, average.
    function automatic int model(input logic [1:0] mode, input arr6_t w, input arr6_t vg, input arr6_t vd);
        int q[$];
        int vov, m, a, b, c;
        for (int i = 0; i < 6; i++) begin
            vov = (vg[i] >= 1) ? vg[i] - 1 : 0;
            if (mode[0]) m = (vd[i] <= vov) ? 2 * vov * vd[i] - vd[i] * vd[i] : vov * vov;
            else         m = (vd[i] <= vov) ? 2 * vd[i] : 2 * vov;
            q.push_back(w[i] * m);
        end
        q.sort();
        if (mode[1]) begin a = q[5] / 3; b = q[4] / 3; c = q[3] / 3; end
        else         begin a = q[2] / 3; b = q[1] / 3; c = q[0] / 3; end
        return mode[0] ? (3 * a + 4 * b + 5 * c) / 12 : (a + b + c) / 3;
    endfunction

    task automatic send_beat(input logic [1:0] mode, input int w, input int vg, input int vd, input int gap);
        repeat (gap) @(negedge clk);
        chk("in_ready_beat", int'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.in_mode  = mode;
        bus.in_w     = 3'(w);
        bus.in_vgs   = 3'(vg);
        bus.in_vds   = 3'(vd);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Later beats carry a random mode, which the block must ignore.
    task automatic send_pkt(input logic [1:0] mode, input arr6_t w, input arr6_t vg, input arr6_t vd, input int maxgap);
        logic [1:0] m;
        for (int b = 0; b < 6; b++) begin
            m = (b == 0) ? mode : 2'($urandom_range(0, 3));
            send_beat(m, w[b], vg[b], vd[b], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        end
    endtask

    task automatic finish_pkt(input string nm, input int exp, input int bp);
        chk({nm, "_calc_valid"}, int'(bus.out_valid), 0);
        chk({nm, "_calc_ready"}, int'(bus.in_ready), 0);
        @(negedge clk);
        chk({nm, "_out_valid"}, int'(bus.out_valid), 1);
        chk({nm, "_out_data"}, int'(bus.out_data), exp);
        for (int k = 0; k < bp; k++) begin
            bus.in_valid = ~bus.in_valid;
            bus.in_w = 3'd7; bus.in_vgs = 3'd7; bus.in_vds = 3'd7;
            @(negedge clk);
            chk({nm, "_bp_valid"}, int'(bus.out_valid), 1);
            chk({nm, "_bp_data"}, int'(bus.out_data), exp);
            chk({nm, "_bp_ready"}, int'(bus.in_ready), 0);
        end
        // A beat offered during the handshake cycle must be dropped.
        bus.in_valid  = 1'b1;
        bus.in_w = 3'd7; bus.in_vgs = 3'd7; bus.in_vds = 3'd7;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk({nm, "_done_valid"}, int'(bus.out_valid), 0);
        chk({nm, "_done_data"}, int'(bus.out_data), 0);
        chk({nm, "_done_ready"}, int'(bus.in_ready), 1);
    endtask

    vec_t tbl[6];
    arr6_t rw, rg, rd;
    logic [1:0] rm;

    initial begin
        bus.in_valid = 0; bus.in_mode = 0; bus.in_w = 0; bus.in_vgs = 0; bus.in_vds = 0;
        bus.out_ready = 0;

        for (int t = 0; t < 4; t++) begin
            tbl[t].mode = 2'(t == 0 ? 0 : t == 1 ? 2 : t == 2 ? 1 : 3);
            tbl[t].w    = '{1, 2, 3, 4, 5, 6};
            tbl[t].vg   = '{4, 4, 4, 4, 4, 4};
            tbl[t].vd   = '{5, 5, 5, 5, 5, 5};
        end
        tbl[0].exp = 4; tbl[1].exp = 10; tbl[2].exp = 5; tbl[3].exp = 14;
        tbl[4].mode = 2'b11; tbl[4].w = '{7,7,7,7,7,7}; tbl[4].vg = '{7,7,7,7,7,7};
        tbl[4].vd = '{7,7,7,7,7,7}; tbl[4].exp = 84;
        tbl[5].mode = 2'b01; tbl[5].w = '{2,2,2,2,2,2}; tbl[5].vg = '{5,5,5,5,5,5};
        tbl[5].vd = '{2,2,2,2,2,2}; tbl[5].exp = 8;

        #2;
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed table, gap-free then with random gaps; backpressure on one.
        for (int t = 0; t < 6; t++) begin
            send_pkt(tbl[t].mode, tbl[t].w, tbl[t].vg, tbl[t].vd, 0);
            finish_pkt($sformatf("tbl%0d", t), tbl[t].exp, (t == 1) ? 5 : 0);
        end
        for (int t = 0; t < 6; t++) begin
            send_pkt(tbl[t].mode, tbl[t].w, tbl[t].vg, tbl[t].vd, 3);
            finish_pkt($sformatf("gap%0d", t), tbl[t].exp, 0);
        end

        // Mid-packet reset.
        for (int b = 0; b < 3; b++) send_beat(2'b11, 7, 7, 7, 0);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", int'(bus.in_ready), 1);
        chk("midrst_out_valid", int'(bus.out_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        send_pkt(tbl[0].mode, tbl[0].w, tbl[0].vg, tbl[0].vd, 0);
        finish_pkt("after_midrst", 4, 0);

        // Reset while a result is pending.
        send_pkt(tbl[1].mode, tbl[1].w, tbl[1].vg, tbl[1].vd, 0);
        @(negedge clk);
        chk("pend_valid", int'(bus.out_valid), 1);
        rst = 1'b1;
        #1;
        chk("pendrst_valid", int'(bus.out_valid), 0);
        chk("pendrst_data", int'(bus.out_data), 0);
        chk("pendrst_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        send_pkt(tbl[2].mode, tbl[2].w, tbl[2].vg, tbl[2].vd, 1);
        finish_pkt("after_pendrst", 5, 0);

        // Random packets against the reference model.
        for (int r = 0; r < 30; r++) begin
            rm = 2'($urandom_range(0, 3));
            for (int i = 0; i < 6; i++) begin
                rw[i] = $urandom_range(0, 7);
                rg[i] = $urandom_range(0, 7);
                rd[i] = $urandom_range(0, 7);
            end
            send_pkt(rm, rw, rg, rd, 2);
            finish_pkt($sformatf("rnd%0d", r), model(rm, rw, rg, rd), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
